// File: rtl/react_timer.sv
// react_timer: timing datapath behind the reaction-test state machine.
// Owns the ms prescaler, the LFSR-drawn pre-stimulus delay and the
// saturating reaction counter. Its three status flags feed back into the
// state machine as {cleared, overflow, start}.
//
// machine_state | meaning
// --------------+--------------------------------------------------
// 0 IDLE        | everything cleared, no timing
// 1 WAIT        | random delay running; start flags when it expires
// 2 CLR_CNT1    | clear reaction count before a trial
// 3 START       | stimulus lit, reaction count runs in ms
// 4 STORAGE     | count frozen while the result is stored
// 5 CLR_CNT2    | clear reaction count between trials
// 6 AVERAGE     | count frozen
// 7 COMPARE     | count frozen
module react_timer #(
    parameter int CLK_DIV      = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  machine_state,
    output logic [2:0]  timer_signals,
    output logic [15:0] react_time,
    output logic        go_led
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]      MAX_CNT  = 16'(MAX_MS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_CLR1  = 3'd2,
        ST_START = 3'd3,
        ST_STORE = 3'd4,
        ST_CLR2  = 3'd5,
        ST_AVG   = 3'd6,
        ST_CMP   = 3'd7
    } mstate_t;

    mstate_t          state;
    mstate_t          prev_state;
    logic [15:0]      lfsr;
    logic [DIV_W-1:0] div_left;
    logic [DLY_W-1:0] delay_cnt;
    logic [DLY_W-1:0] target;
    logic             armed;
    logic [15:0]      react_q;

    logic             entry;
    logic             is_wait;
    logic             is_start;
    logic             is_clr;
    logic             count_en;
    logic             tick;
    logic [DIV_W-1:0] div_nxt;
    logic [DLY_W-1:0] delay_nxt;
    logic [DLY_W-1:0] target_nxt;
    logic             armed_nxt;
    logic [15:0]      react_nxt;
    logic             lfsr_fb;

    // Decode the incoming state code and the per-state qualifiers.
    always_comb begin
        state    = mstate_t'(machine_state);
        entry    = (state != prev_state);
        is_wait  = (state == ST_WAIT);
        is_start = (state == ST_START);
        is_clr   = (state == ST_CLR1) || (state == ST_CLR2);
    end

    // Prescaler is a down-counter: tick on terminal count zero, then reload.
    // Any state entry or non-timing state reloads it, so the first tick lands
    // CLK_DIV cycles after the entry edge.
    always_comb begin
        count_en = !entry && ((is_wait && armed) || is_start);
        tick     = count_en && (div_left == '0);
        div_nxt  = (count_en && !tick) ? (div_left - DIV_W'(1)) : DIV_LOAD;
    end

    // Per-state next values for the delay timer, arming and reaction count.
    // armed drops in every state other than WAIT so a stale delay/target match
    // can never flash start on the entry cycle of a later WAIT.
    always_comb begin
        delay_nxt  = delay_cnt;
        target_nxt = target;
        armed_nxt  = 1'b0;
        react_nxt  = react_q;
        case (state)
            ST_IDLE: begin
                react_nxt = '0;
                delay_nxt = '0;
            end
            ST_WAIT: begin
                if (entry) begin
                    target_nxt = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
                    delay_nxt  = '0;
                    armed_nxt  = 1'b1;
                end else begin
                    armed_nxt = armed;
                    if (tick && (delay_cnt < target))
                        delay_nxt = delay_cnt + DLY_W'(1);
                end
            end
            ST_CLR1, ST_CLR2: begin
                react_nxt = '0;
            end
            ST_START: begin
                if (tick && (react_q < MAX_CNT))
                    react_nxt = react_q + 16'd1;
            end
            default: begin
            end
        endcase
    end

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // State register: every timer/counter register plus the free-running LFSR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr       <= 16'hACE1;
            prev_state <= ST_IDLE;
            div_left   <= DIV_LOAD;
            delay_cnt  <= '0;
            target     <= '0;
            armed      <= 1'b0;
            react_q    <= '0;
        end else begin
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            prev_state <= state;
            div_left   <= div_nxt;
            delay_cnt  <= delay_nxt;
            target     <= target_nxt;
            armed      <= armed_nxt;
            react_q    <= react_nxt;
        end
    end

    // Status flags are plain decodes; rstn gates them so nothing is driven
    // while reset is held, whatever state code is presented.
    always_comb begin
        timer_signals[0] = rstn && is_wait && armed && (delay_cnt == target);
        timer_signals[1] = rstn && is_start && (react_q == MAX_CNT);
        timer_signals[2] = rstn && is_clr && (react_q == '0);
        go_led           = rstn && is_start;
        react_time       = react_q;
    end

endmodule

// File: tb/tb_react_timer.sv
// Bench for react_timer: a per-cycle model derived from elapsed time in each
// state, plus directed scenarios with hand-computed literal results.
module tb_react_timer;

    localparam int CLK_DIV      = 4;
    localparam int MIN_DELAY_MS = 3;
    localparam int RAND_BITS    = 2;
    localparam int MAX_MS       = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_CLR1  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_CLR2  = 3'd5;
    localparam logic [2:0] S_AVG   = 3'd6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  machine_state = 3'd0;
    logic [2:0]  timer_signals;
    logic [15:0] react_time;
    logic        go_led;

    int tests = 0;
    int fails = 0;

    react_timer #(
        .CLK_DIV     (CLK_DIV),
        .MIN_DELAY_MS(MIN_DELAY_MS),
        .RAND_BITS   (RAND_BITS),
        .MAX_MS      (MAX_MS)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .machine_state(machine_state),
        .timer_signals(timer_signals),
        .react_time   (react_time),
        .go_led       (go_led)
    );

    always #5 clk = ~clk;

    // Model: time spent in the current state since its entry edge decides
    // everything. Delay elapsed = n / CLK_DIV ms, reaction = base + n / CLK_DIV
    // clipped at MAX_MS.
    int          m_react  = 0;
    int          m_base   = 0;
    int          m_target = 0;
    int          m_n      = 0;
    bit          m_armed  = 1'b0;
    logic [2:0]  m_prev   = 3'd0;
    logic [15:0] m_lfsr   = 16'hACE1;
    bit          done     = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [2:0] s;
        bit         ent;
        int         r;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_react  = 0;
                m_target = 0;
                m_n      = 0;
                m_armed  = 1'b0;
                m_prev   = S_IDLE;
                m_lfsr   = 16'hACE1;
            end else begin
                s   = machine_state;
                ent = (s != m_prev);
                case (s)
                    S_IDLE: begin
                        m_react = 0;
                        m_armed = 1'b0;
                    end
                    S_WAIT: begin
                        if (ent) begin
                            m_target = MIN_DELAY_MS + (int'(m_lfsr) % (1 << RAND_BITS));
                            m_n      = 0;
                            m_armed  = 1'b1;
                        end else begin
                            m_n++;
                        end
                    end
                    S_CLR1, S_CLR2: begin
                        m_react = 0;
                        m_armed = 1'b0;
                    end
                    S_START: begin
                        m_armed = 1'b0;
                        if (ent) begin
                            m_base = m_react;
                            m_n    = 0;
                        end else begin
                            m_n++;
                            r       = m_base + m_n / CLK_DIV;
                            m_react = (r > MAX_MS) ? MAX_MS : r;
                        end
                    end
                    default: m_armed = 1'b0;
                endcase
                m_lfsr = lfsr_step(m_lfsr);
                m_prev = s;
            end
        end
    end

    // Compare every cycle, 1 time unit after the active edge.
    initial begin
        logic [2:0] s;
        int         e_react;
        logic [2:0] e_sig;
        logic       e_go;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                s        = machine_state;
                e_react  = rstn ? m_react : 0;
                e_sig[0] = rstn && (s == S_WAIT) && m_armed && ((m_n / CLK_DIV) >= m_target);
                e_sig[1] = rstn && (s == S_START) && (m_react == MAX_MS);
                e_sig[2] = rstn && ((s == S_CLR1) || (s == S_CLR2)) && (m_react == 0);
                e_go     = rstn && (s == S_START);
                check("cyc_react_time", 32'(react_time), 32'(e_react));
                check("cyc_timer_signals", 32'(timer_signals), 32'(e_sig));
                check("cyc_go_led", 32'(go_led), 32'(e_go));
            end
        end
    end

    task automatic hold(input logic [2:0] s, input int n);
        machine_state = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] s);
        rstn          = 1'b0;
        machine_state = s;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        machine_state = S_IDLE;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // 1: idle after reset
        hold(S_IDLE, 20);
        check("idle_react", 32'(react_time), 32'd0);
        check("idle_signals", 32'(timer_signals), 32'd0);
        check("idle_go", 32'(go_led), 32'd0);

        // 2: WAIT straight out of reset: lfsr ACE1 -> target 4, start after 16 clk
        do_reset(S_WAIT);
        hold(S_WAIT, 16);
        check("wait_model_target", 32'(m_target), 32'd4);
        check("wait_before_start", 32'(timer_signals), 32'b000);
        @(negedge clk);
        check("wait_start_rise", 32'(timer_signals), 32'b001);
        hold(S_WAIT, 5);
        check("wait_start_held", 32'(timer_signals), 32'b001);

        // CLR with a count already zero: cleared without latency
        machine_state = S_CLR1;
        #1;
        check("clr_zero_latency", 32'(timer_signals), 32'b100);
        @(negedge clk);

        // 4: START 22 clk then STORAGE freezes at 5
        hold(S_START, 22);
        check("start22_react", 32'(react_time), 32'd5);
        check("start22_signals", 32'(timer_signals), 32'b000);
        check("start22_go", 32'(go_led), 32'd1);
        hold(S_STORE, 6);
        check("store_frozen", 32'(react_time), 32'd5);
        check("store_go", 32'(go_led), 32'd0);

        // WAIT re-entered from AVERAGE keeps the displayed value
        hold(S_AVG, 3);
        hold(S_WAIT, 30);
        check("rewait_react_hold", 32'(react_time), 32'd5);
        check("rewait_start", 32'(timer_signals), 32'b001);
        machine_state = S_CLR2;
        #1;
        check("clr2_before_edge", 32'(timer_signals), 32'b000);
        @(negedge clk);
        check("clr2_react", 32'(react_time), 32'd0);
        check("clr2_cleared", 32'(timer_signals), 32'b100);

        // 3: react_time 7, then CLR_CNT1 clears with one cycle latency
        hold(S_START, 30);
        check("start30_react", 32'(react_time), 32'd7);
        machine_state = S_CLR1;
        #1;
        check("clr1_pending", 32'(timer_signals), 32'b000);
        @(negedge clk);
        check("clr1_react", 32'(react_time), 32'd0);
        check("clr1_cleared", 32'(timer_signals), 32'b100);
        machine_state = S_START;
        #1;
        check("start_entry_signals", 32'(timer_signals), 32'b000);
        check("start_entry_go", 32'(go_led), 32'd1);
        @(negedge clk);

        // 5: saturation at 10 after 40 clk
        hold(S_START, 39);
        check("sat_before_react", 32'(react_time), 32'd9);
        check("sat_before_ovf", 32'(timer_signals), 32'b000);
        @(negedge clk);
        check("sat_react", 32'(react_time), 32'd10);
        check("sat_ovf", 32'(timer_signals), 32'b010);
        hold(S_START, 19);
        check("sat_held_react", 32'(react_time), 32'd10);
        check("sat_held_ovf", 32'(timer_signals), 32'b010);
        machine_state = S_STORE;
        #1;
        check("sat_store_signals", 32'(timer_signals), 32'b000);
        hold(S_STORE, 5);
        check("sat_store_react", 32'(react_time), 32'd10);

        // 6: async reset mid-START with react_time 6
        hold(S_CLR1, 2);
        hold(S_START, 26);
        check("pre_reset_react", 32'(react_time), 32'd6);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_react", 32'(react_time), 32'd0);
        check("async_rst_signals", 32'(timer_signals), 32'b000);
        check("async_rst_go", 32'(go_led), 32'd0);
        machine_state = S_WAIT;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        hold(S_WAIT, 16);
        check("post_rst_target_lo", 32'(m_target >= 3), 32'd1);
        check("post_rst_target_hi", 32'(m_target <= 6), 32'd1);
        check("post_rst_no_start", 32'(timer_signals), 32'b000);
        @(negedge clk);
        check("post_rst_start", 32'(timer_signals), 32'b001);
        hold(S_IDLE, 3);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/react_timer.md
Name: react_timer

Overview:
- Timing datapath that answers the reaction-test state machine.
- Decodes the current 3-bit machine state and produces the three timer-side status signals, {cleared, overflow, start}, which drive bits [6:4] of the state machine's signal bus.
- Also produces the 16-bit measured reaction time and the "go" stimulus LED.
- Contains the ms prescaler, pseudo-random pre-stimulus delay (LFSR), and saturating reaction counter.

Parameters:
CLK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk)
MIN_DELAY_MS, 1000, minimum random delay before stimulus, ms
RAND_BITS, 11, LFSR bits added to MIN_DELAY_MS (delay range MIN..MIN+2^RAND_BITS-1)
MAX_MS, 999, reaction count saturation / overflow point; 8*MAX_MS must fit 13 bits

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
machine_state  input  3  state code: 0 IDLE, 1 WAIT, 2 CLR_CNT1, 3 START, 4 STORAGE, 5 CLR_CNT2, 6 AVERAGE, 7 COMPARE
timer_signals  output  3  [2] cleared, [1] overflow, [0] start; maps to state-machine signals[6:4]
react_time  output  16  measured reaction time, ms, zero-extended (only [12:0] consumed)
go_led  output  1  stimulus light, high while machine_state==START

Behaviour:
- Reset (async, rstn low): react_time=0, delay_cnt=0, div_cnt=0, target=0, armed=0, prev_state=IDLE, lfsr=16'hACE1. All outputs 0 during reset.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clk regardless of state; never reaches 0.
- Prescaler: div_cnt counts 0..CLK_DIV-1 only in WAIT (when armed) and START. tick=1 in the cycle div_cnt==CLK_DIV-1, then div_cnt wraps to 0. div_cnt is cleared in every other state and on every state entry.
- Entry detection: prev_state is registered each clk. entry = (machine_state != prev_state).
- IDLE:
  - react_time=0, delay_cnt=0, armed=0.
  - timer_signals=0.
- WAIT:
  - On the entry cycle: target <= MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; delay_cnt <= 0; div_cnt <= 0; armed <= 1.
  - Thereafter delay_cnt increments on tick, saturating at target.
  - start = (state==WAIT) && armed && (delay_cnt==target). start is a level held until the state leaves WAIT.
  - react_time holds its last value (display of the previous trial is kept).
- CLR_CNT1 / CLR_CNT2:
  - Every cycle: react_time <= 0, div_cnt <= 0, armed <= 0.
  - cleared = (state is CLR_CNT1 or CLR_CNT2) && react_time==0. This gives 1-cycle latency after entry if react_time was nonzero, 0 cycles if already zero.
- START:
  - On tick, react_time increments while react_time < MAX_MS; at MAX_MS it holds (saturates).
  - overflow = (state==START) && react_time==MAX_MS; held as a level while in START.
  - First increment occurs CLK_DIV cycles after entry.
- STORAGE / AVERAGE / COMPARE:
  - react_time frozen at its final value; no counting; timer_signals=0.
- Timer signals are pure decodes of registered values and the current machine_state: no extra pipeline stage. Each is 0 outside its owning state(s).
- Boundary cases:
  - React press in the same cycle as overflow: counter stays at MAX_MS; STORAGE receives MAX_MS.
  - State leaving START mid-count: counter freezes at its current value in that cycle.
  - WAIT re-entered from AVERAGE (skipping CLR): a new random target is drawn and react_time still holds; the following CLR clears it.
  - react_time never exceeds MAX_MS; bits [15:13] are always 0 for legal MAX_MS.
  - Reset asserted mid-WAIT or mid-START: immediate return to reset values; after release the design restarts from IDLE behaviour.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2, MAX_MS=10.
1. Reset, hold state=IDLE 20 clk -> timer_signals=3'b000, react_time=0, go_led=0.
2. state=WAIT after reset (lfsr=ACE1, lfsr[1:0]=1 at entry) -> target=4. start rises exactly 16 clk (4 ticks) after the entry cycle and stays high until state=CLR_CNT1.
3. react_time=7, state=CLR_CNT1 -> react_time=0 next clk, cleared=1 from that cycle; state=START -> cleared=0, go_led=1.
4. START held 22 clk, then state=STORAGE -> react_time=5 (ticks at clk 4,8,12,16,20), frozen thereafter; overflow=0 throughout.
5. START held 60 clk -> react_time saturates at 10 after 40 clk, overflow=1 from that cycle until exit; STORAGE keeps 10.
6. rstn pulsed low mid-START with react_time=6 -> react_time=0 and all timer_signals 0 immediately (asynchronously, not waiting for clk); state=WAIT afterwards draws a fresh target within 3..6.
